// File: rtl/seg7_scan_display.sv
// rtl/seg7_scan_display.sv - time-multiplexed hex display with freeze/snapshot
// Optional: define SEG7_LEADZERO_BLANK_EN to blank leading zero digits.
module seg7_scan_display #(
  parameter int DIGITS   = 8,
  parameter int SCAN_DIV = 1000
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                enable,
  input  logic [4*DIGITS-1:0] data_in,
  input  logic                hold,
  input  logic                capture,
  output logic [7:0]          seg_out,
  output logic [DIGITS-1:0]   digit_sel,
  output logic                held
);
  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

  function automatic logic [6:0] hex_decode(input logic [3:0] nib);
    case (nib)
      4'h0:    hex_decode = 7'b1111110;
      4'h1:    hex_decode = 7'b0110000;
      4'h2:    hex_decode = 7'b1101101;
      4'h3:    hex_decode = 7'b1111001;
      4'h4:    hex_decode = 7'b0110011;
      4'h5:    hex_decode = 7'b1011011;
      4'h6:    hex_decode = 7'b1011111;
      4'h7:    hex_decode = 7'b1110000;
      4'h8:    hex_decode = 7'b1111111;
      4'h9:    hex_decode = 7'b1111011;
      4'hA:    hex_decode = 7'b1110111;
      4'hB:    hex_decode = 7'b0011111;
      4'hC:    hex_decode = 7'b0001101;
      4'hD:    hex_decode = 7'b0111101;
      4'hE:    hex_decode = 7'b1001111;
      default: hex_decode = 7'b1000111;
    endcase
  endfunction

  logic [4*DIGITS-1:0] snap_q, snap_d;
  logic                cap_dly_q, cap_dly_d;
  logic [PW-1:0]       pre_q, pre_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [7:0]          seg_q, seg_d;
  logic [DIGITS-1:0]   sel_q, sel_d;
  logic                held_q, held_d;
  logic [3:0]          cur_nib;
  logic                blank;

  assign cur_nib = snap_q[4*idx_q +: 4];

`ifdef SEG7_LEADZERO_BLANK_EN
  // zero_from[k]: every nibble from the top digit down to k is zero
  logic [DIGITS-1:0] zero_from;
  always_comb begin
    zero_from[DIGITS-1] = (snap_q[4*DIGITS-1 -: 4] == 4'h0);
    for (int k = DIGITS - 2; k >= 0; k--) begin
      zero_from[k] = zero_from[k+1] & (snap_q[4*k +: 4] == 4'h0);
    end
  end
  assign blank = (idx_q != '0) && zero_from[idx_q];
`else
  assign blank = 1'b0;
`endif

  always_comb begin
    cap_dly_d = capture;
    held_d    = hold;
    snap_d    = snap_q;
    if (!hold || (capture && !cap_dly_q)) begin
      snap_d = data_in;
    end
    pre_d = pre_q;
    idx_d = idx_q;
    seg_d = '0;
    sel_d = '0;
    if (enable) begin
      if (pre_q == PRE_LAST) begin
        pre_d = '0;
        idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
      end else begin
        pre_d = pre_q + 1'b1;
      end
      sel_d[idx_q] = 1'b1;
      seg_d = {(blank ? 7'b0 : hex_decode(cur_nib)), (held_q && (idx_q == '0))};
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      snap_q    <= '0;
      cap_dly_q <= 1'b0;
      pre_q     <= '0;
      idx_q     <= '0;
      seg_q     <= '0;
      sel_q     <= '0;
      held_q    <= 1'b0;
    end else begin
      snap_q    <= snap_d;
      cap_dly_q <= cap_dly_d;
      pre_q     <= pre_d;
      idx_q     <= idx_d;
      seg_q     <= seg_d;
      sel_q     <= sel_d;
      held_q    <= held_d;
    end
  end

  assign seg_out   = seg_q;
  assign digit_sel = sel_q;
  assign held      = held_q;

endmodule

// File: tb/tb_seg7_scan_display.sv
// tb/tb_seg7_scan_display.sv - scoreboard bench for seg7_scan_display
module tb_seg7_scan_display;
  localparam int D  = 4;
  localparam int SD = 3;

  logic        clock = 1'b0;
  logic        reset;
  logic        enable;
  logic        hold;
  logic        capture;
  logic [15:0] data_in;
  logic [7:0]  seg_out;
  logic [3:0]  digit_sel;
  logic        held;

  int checks = 0;
  int errors = 0;

  logic [12:0] exp_q[$];
  logic [12:0] mon_e;

  logic [6:0] dec_tab [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b0001101, 7'b0111101, 7'b1001111, 7'b1000111
  };

  seg7_scan_display #(.DIGITS(D), .SCAN_DIV(SD)) dut (
    .clock     (clock),
    .reset     (reset),
    .enable    (enable),
    .data_in   (data_in),
    .hold      (hold),
    .capture   (capture),
    .seg_out   (seg_out),
    .digit_sel (digit_sel),
    .held      (held)
  );

  always #5 clock = ~clock;

  // Reference model: one expected output word per clock edge
  logic [15:0] m_snap;
  logic        m_cap;
  logic        m_held;
  int          m_pre;
  int          m_idx;
  logic [6:0]  m_segs;
  logic [7:0]  e_seg;
  logic [3:0]  e_sel;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_snap = '0;
      m_cap  = 1'b0;
      m_held = 1'b0;
      m_pre  = 0;
      m_idx  = 0;
      exp_q.delete();
      exp_q.push_back('0);
    end else begin
      e_seg = '0;
      e_sel = '0;
      if (enable) begin
        e_sel  = 4'(1 << m_idx);
        m_segs = dec_tab[m_snap[m_idx*4 +: 4]];
`ifdef SEG7_LEADZERO_BLANK_EN
        if (m_idx != 0 && (m_snap >> (4*m_idx)) == 16'h0) m_segs = '0;
`endif
        e_seg = {m_segs, (m_held && m_idx == 0)};
        if (m_pre == SD - 1) begin
          m_pre = 0;
          m_idx = (m_idx + 1) % D;
        end else begin
          m_pre = m_pre + 1;
        end
      end
      if (!hold || (capture && !m_cap)) m_snap = data_in;
      m_cap  = capture;
      m_held = hold;
      exp_q.push_back({e_seg, e_sel, hold});
    end
  end

  always @(negedge clock) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      checks++;
      if ({seg_out, digit_sel, held} !== mon_e) begin
        errors++;
        $display("FAIL scoreboard t=%0t seg=%b sel=%b held=%b expected seg=%b sel=%b held=%b",
                 $time, seg_out, digit_sel, held, mon_e[12:5], mon_e[4:1], mon_e[0]);
      end
    end
  end

  task automatic run(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic expect_digit(input logic [3:0] sel, input logic [7:0] seg, input string name);
    int n;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (digit_sel !== sel && n < 40);
    checks++;
    if (digit_sel !== sel) begin
      errors++;
      $display("FAIL %s timeout sel=%b expected %b", name, digit_sel, sel);
    end else if (seg_out !== seg) begin
      errors++;
      $display("FAIL %s seg=%b expected %b", name, seg_out, seg);
    end
  endtask

  task automatic expect_outputs(input logic [7:0] seg, input logic [3:0] sel,
                                input logic hl, input string name);
    checks++;
    if ({seg_out, digit_sel, held} !== {seg, sel, hl}) begin
      errors++;
      $display("FAIL %s seg=%b sel=%b held=%b expected seg=%b sel=%b held=%b",
               name, seg_out, digit_sel, held, seg, sel, hl);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; enable = 1'b1; hold = 1'b0; capture = 1'b0; data_in = 16'h0000;
    run(3);
    expect_outputs(8'h00, 4'b0000, 1'b0, "in_reset");
    reset = 1'b1;
    expect_digit(4'b0001, 8'b11111100, "first_clock");
    run(14);

    data_in = 16'hA5C3;
    run(14);
    expect_digit(4'b0001, 8'b11110010, "a5c3_d0");
    expect_digit(4'b0010, 8'b00011010, "a5c3_d1");
    expect_digit(4'b0100, 8'b10110110, "a5c3_d2");
    expect_digit(4'b1000, 8'b11101110, "a5c3_d3");

    hold = 1'b1;
    run(1);
    data_in = 16'h1234;
    run(14);
    expect_digit(4'b0001, 8'b11110011, "frozen_d0_dp");
    expect_digit(4'b1000, 8'b11101110, "frozen_d3");

    capture = 1'b1;
    run(1);
    capture = 1'b0;
    run(1);
    data_in = 16'hFFFF;
    run(14);
    expect_digit(4'b0001, 8'b01100111, "captured_d0");
    expect_digit(4'b1000, 8'b01100000, "captured_d3");

    expect_digit(4'b0100, 8'b11011010, "pre_disable");
    enable = 1'b0;
    run(1);
    expect_outputs(8'h00, 4'b0000, 1'b1, "disabled_dark");
    run(3);
    enable = 1'b1;
    expect_digit(4'b0100, 8'b11011010, "resume_same_digit");
    expect_digit(4'b1000, 8'b01100000, "resume_next_digit");
    run(14);

    hold = 1'b0;
    data_in = 16'h0070;
    run(14);
`ifdef SEG7_LEADZERO_BLANK_EN
    expect_digit(4'b1000, 8'b00000000, "lz_d3");
`else
    expect_digit(4'b1000, 8'b11111100, "lz_d3");
`endif
    expect_digit(4'b0001, 8'b11111100, "lz_d0");
    expect_digit(4'b0010, 8'b11100000, "lz_d1");

    hold = 1'b1;
    run(3);
    @(posedge clock);
    #2;
    reset = 1'b0;
    #1;
    expect_outputs(8'h00, 4'b0000, 1'b0, "async_reset");
    @(negedge clock);
    reset = 1'b1;
    run(5);
    expect_digit(4'b0001, 8'b11111101, "snap_cleared");
    run(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
